// File: rtl/clkswitch_pkg.sv
// Shared types and reset constants for the 65816 PHI2 clock switch.
// State encoding plus the power-on values of every register.
package clkswitch_pkg;

  typedef enum logic [1:0] {
    LS_RUN  = 2'd0,
    HS_RUN  = 2'd1,
    WAIT_LS = 2'd2
  } state_t;

  localparam state_t RST_STATE  = LS_RUN;
  localparam logic   RST_CLKOUT = 1'b1;
  localparam logic   RST_SYNC   = 1'b1;
  localparam logic   RST_RDY    = 1'b1;
  localparam logic   RST_HS_SEL = 1'b0;
  localparam logic   RST_LS_SEL = 1'b1;

endpackage

// File: rtl/clkswitch_sync_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Resets to RST_VAL so the consumer sees a known level immediately.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sr <= {STAGES{RST_VAL}};
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/clkswitch_sync.sv
// PHI2 generator: divided hsclk or synchronised lsclk, switched only
// while clkout is high so the CPU never sees a runt phase.
import clkswitch_pkg::*;

module clkswitch_sync #(
  parameter int DIV_W         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int RDY_ON_SWITCH = 1
) (
  input  logic             hsclk_in,
  input  logic             rst_b,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] div_sel,
  output logic             clkout,
  output logic             hsclk_selected,
  output logic             lsclk_selected,
  output logic             rdy,
  output logic             phi2_end
);

  localparam logic RDY_EN = (RDY_ON_SWITCH != 0);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             ls_s;
  logic             ls_d;

  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_SYNC)
  ) u_ls_sync (
    .clk   (hsclk_in),
    .rst_b (rst_b),
    .d     (lsclk_in),
    .q     (ls_s)
  );

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state          <= RST_STATE;
      clkout         <= RST_CLKOUT;
      cnt            <= '0;
      div_q          <= '0;
      ls_d           <= RST_SYNC;
      hsclk_selected <= RST_HS_SEL;
      lsclk_selected <= RST_LS_SEL;
      rdy            <= RST_RDY;
      phi2_end       <= 1'b0;
    end else begin
      ls_d     <= ls_s;
      phi2_end <= 1'b0;
      unique case (state)
        LS_RUN: begin
          // ls_s leads clkout by one cycle, so this is mid-high
          if (hsclk_sel && clkout && ls_s) begin
            state          <= HS_RUN;
            cnt            <= div_sel;
            div_q          <= div_sel;
            hsclk_selected <= 1'b1;
            lsclk_selected <= 1'b0;
            rdy            <= 1'b1;
          end else begin
            clkout   <= ls_s;
            phi2_end <= clkout & ~ls_s;
            rdy      <= ~(RDY_EN & hsclk_sel);
          end
        end
        HS_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!clkout) begin
            clkout <= 1'b1;
            cnt    <= div_sel;
            div_q  <= div_sel;
          end else if (hsclk_sel) begin
            clkout   <= 1'b0;
            cnt      <= div_q;
            phi2_end <= 1'b1;
          end else begin
            state          <= WAIT_LS;
            hsclk_selected <= 1'b0;
            rdy            <= ~RDY_EN;
          end
        end
        WAIT_LS: begin
          if (hsclk_sel) begin
            state          <= HS_RUN;
            cnt            <= div_sel;
            div_q          <= div_sel;
            hsclk_selected <= 1'b1;
            rdy            <= 1'b1;
          end else if (ls_s && !ls_d) begin
            state          <= LS_RUN;
            lsclk_selected <= 1'b1;
            rdy            <= 1'b1;
          end
        end
        default: begin
          state          <= RST_STATE;
          clkout         <= RST_CLKOUT;
          hsclk_selected <= RST_HS_SEL;
          lsclk_selected <= RST_LS_SEL;
          rdy            <= RST_RDY;
        end
      endcase
    end
  end

endmodule
